// File: rtl/sigmoid_inverse_pwl_if.sv
// rtl/sigmoid_inverse_pwl_if.sv - valid/ready stream bundle for the inverse sigmoid unit
interface sigmoid_inverse_pwl_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] y;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] x;

   modport master (
      output in_valid, y, out_ready,
      input  in_ready, out_valid, x
   );

   modport slave (
      input  in_valid, y, out_ready,
      output in_ready, out_valid, x
   );
endinterface

// File: rtl/sigmoid_inverse_pwl.sv
// rtl/sigmoid_inverse_pwl.sv - 3-stage piecewise-linear logit (inverse sigmoid) pipeline
module sigmoid_inverse_pwl #(
   parameter int DATA_W = 32,
   parameter int ONE    = 1872,
   parameter int HALF   = 936,
   parameter int X_SAT  = 13549
) (
   input  logic                 clk,
   input  logic                 reset,
   sigmoid_inverse_pwl_if.slave bus
);
   // Segment table shared with the forward sigmoid path.
   function automatic logic [DATA_W-1:0] thr(input int idx);
      case (idx)
         0: thr = DATA_W'(936);
         1: thr = DATA_W'(1434);
         2: thr = DATA_W'(1687);
         3: thr = DATA_W'(1783);
         4: thr = DATA_W'(1827);
         5: thr = DATA_W'(1849);
         6: thr = DATA_W'(1858);
         7: thr = DATA_W'(1864);
         default: thr = DATA_W'(1872);
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] icpt(input logic [2:0] idx);
      case (idx)
         3'd0: icpt = DATA_W'(936);
         3'd1: icpt = DATA_W'(1185);
         3'd2: icpt = DATA_W'(1434);
         3'd3: icpt = DATA_W'(1609);
         3'd4: icpt = DATA_W'(1719);
         3'd5: icpt = DATA_W'(1785);
         3'd6: icpt = DATA_W'(1821);
         default: icpt = DATA_W'(1843);
      endcase
   endfunction

   logic              en;
   logic              v1, v2, v3;
   logic              neg1, neg2;
   logic [DATA_W-1:0] yf1;
   logic              sat2;
   logic [2:0]        k2;
   logic [DATA_W-1:0] d2;
   logic [DATA_W-1:0] x3;

   // Global stall: any blocked output freezes every stage, bubbles included.
   assign en           = !v3 || bus.out_ready;
   assign bus.in_ready = en;
   assign bus.out_valid = v3;
   assign bus.x        = x3;

   logic [2:0]        k_sel;
   logic              sat_sel;
   logic [DATA_W-1:0] mag;

   always_comb begin
      k_sel = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (yf1 >= thr(i)) k_sel = 3'(i);
      end
      sat_sel = (yf1 >= DATA_W'(ONE));
   end

   always_comb begin
      mag = sat2 ? DATA_W'(X_SAT) : (d2 << ({1'b0, k2} + 4'd2));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v1   <= 1'b0;
         v2   <= 1'b0;
         v3   <= 1'b0;
         neg1 <= 1'b0;
         neg2 <= 1'b0;
         yf1  <= '0;
         sat2 <= 1'b0;
         k2   <= 3'd0;
         d2   <= '0;
         x3   <= '0;
      end else if (en) begin
         v1 <= bus.in_valid;
         if (bus.y >= DATA_W'(HALF)) begin
            neg1 <= 1'b0;
            yf1  <= bus.y;
         end else begin
            neg1 <= 1'b1;
            yf1  <= DATA_W'(ONE) - bus.y;
         end

         v2   <= v1;
         neg2 <= neg1;
         sat2 <= sat_sel;
         k2   <= k_sel;
         d2   <= yf1 - icpt(k_sel);

         // One's-complement negation matches the forward path's ~x folding.
         v3 <= v2;
         x3 <= neg2 ? ~mag : mag;
      end
   end
endmodule

// File: tb/tb_sigmoid_inverse_pwl.sv
// tb/tb_sigmoid_inverse_pwl.sv - table-driven scoreboard bench for sigmoid_inverse_pwl
module tb_sigmoid_inverse_pwl;
   localparam int DATA_W = 32;

   typedef struct {
      logic [DATA_W-1:0] y;
      logic [DATA_W-1:0] x;
   } vec_t;

   logic clk;
   logic reset;
   sigmoid_inverse_pwl_if #(.DATA_W(DATA_W)) bus ();

   sigmoid_inverse_pwl #(.DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] cur_exp;
   logic              hold_prev;
   logic [DATA_W-1:0] x_prev;
   vec_t              vecs[12];

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Scoreboard: push on accepted input, pop on accepted output, watch hold stability.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            check("hold_valid", DATA_W'(bus.out_valid), DATA_W'(1));
            check("hold_x", bus.x, x_prev);
         end
         hold_prev = bus.out_valid && !bus.out_ready;
         x_prev    = bus.x;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", DATA_W'(1), DATA_W'(0));
            end else begin
               check("out_x", bus.x, exp_q.pop_front());
            end
         end
         if (bus.in_valid && bus.in_ready) exp_q.push_back(cur_exp);
      end
   end

   // Caller enters just after a posedge; returns just after the accepting posedge.
   task automatic send(input logic [DATA_W-1:0] yv, input logic [DATA_W-1:0] ev);
      logic acc;
      acc          = 1'b0;
      bus.in_valid = 1'b1;
      bus.y        = yv;
      cur_exp      = ev;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) check("send_timeout", DATA_W'(0), DATA_W'(1));
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      check("drain_empty", DATA_W'(exp_q.size()), DATA_W'(0));
   endtask

   initial begin
      vecs[0]  = '{32'd936,  32'd0};
      vecs[1]  = '{32'd1433, 32'd1988};
      vecs[2]  = '{32'd1434, 32'd1992};
      vecs[3]  = '{32'd1687, 32'd4048};
      vecs[4]  = '{32'd1800, 32'd6112};
      vecs[5]  = '{32'd1864, 32'd10752};
      vecs[6]  = '{32'd900,  32'hFFFFFF6F};
      vecs[7]  = '{32'd935,  32'hFFFFFFFB};
      vecs[8]  = '{32'd1872, 32'd13549};
      vecs[9]  = '{32'd5000, 32'd13549};
      vecs[10] = '{32'd0,    32'hFFFFCB12};
      vecs[11] = '{32'd1783, 32'd0 + (32'd174 << 5)};

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.y         = '0;
      bus.out_ready = 1'b1;
      cur_exp       = '0;
      hold_prev     = 1'b0;
      x_prev        = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_out_valid", DATA_W'(bus.out_valid), DATA_W'(0));
         check("reset_x", bus.x, DATA_W'(0));
      end
      @(posedge clk);
      #1 reset = 1'b0;

      // Latency of exactly three cycles on the zero point.
      bus.in_valid = 1'b1;
      bus.y        = 32'd936;
      cur_exp      = 32'd0;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      check("lat_c1", DATA_W'(bus.out_valid), DATA_W'(0));
      @(negedge clk);
      check("lat_c2", DATA_W'(bus.out_valid), DATA_W'(0));
      @(negedge clk);
      check("lat_c3", DATA_W'(bus.out_valid), DATA_W'(1));
      check("lat_x", bus.x, DATA_W'(0));
      @(posedge clk);
      #1;

      // Table streamed back to back.
      for (int i = 0; i < 12; i++) send(vecs[i].y, vecs[i].x);
      drain();

      // Backpressure: three accepted, then in_ready drops while output holds.
      bus.out_ready = 1'b0;
      send(32'd936, 32'd0);
      send(32'd1434, 32'd1992);
      send(32'd1800, 32'd6112);
      bus.in_valid = 1'b1;
      bus.y        = 32'd900;
      cur_exp      = 32'hFFFFFF6F;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready", DATA_W'(bus.in_ready), DATA_W'(0));
         check("bp_x", bus.x, DATA_W'(0));
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      send(32'd900, 32'hFFFFFF6F);
      drain();

      // Reset with three samples in flight.
      send(32'd1687, 32'd4048);
      send(32'd1864, 32'd10752);
      send(32'd0, 32'hFFFFCB12);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_mid_valid", DATA_W'(bus.out_valid), DATA_W'(0));
      @(posedge clk);
      #1;
      send(32'd1434, 32'd1992);
      drain();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("idle_valid", DATA_W'(bus.out_valid), DATA_W'(0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sigmoid_inverse_pwl.md
Name: sigmoid_inverse_pwl

Overview:
- Piecewise-linear inverse sigmoid (logit) unit. Maps a fixed-point probability y, where ONE = 1.0 and HALF = 0.5, back to the pre-activation x.
- Uses the same nine-segment slope/intercept table as the forward sigmoid path, so that x -> sigmoid -> inverse round-trips to within segment quantisation.
- Sits on the backward/decode side of the activation datapath as a 3-stage valid/ready pipeline.

Parameters:
DATA_W, 32, width of y and x
ONE, 1872, fixed-point 1.0 in probability domain
HALF, 936, fixed-point 0.5 (sigmoid(0))
X_SAT, 13549, magnitude returned at or beyond saturation

Ports:
clk  in  1  clock
reset  in  1  sync reset, active-high
in_valid  in  1  y valid
in_ready  out  1  unit accepts y this cycle
y  in  DATA_W  probability, unsigned
out_valid  out  1  x valid
out_ready  in  1  consumer accepts x
x  out  DATA_W  signed pre-activation result

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset state: all stage valid bits 0; out_valid=0; x=0; all pipeline data registers 0.
- Stall: en = !v3 || out_ready.
  - in_ready = en, combinational.
  - Pipeline advances only when en=1. A transfer occurs when valid && ready on either side.
  - When en=0, all stage registers hold.
  - A bubble in S1/S2 does not un-stall a blocked S3; global stall is the accepted behaviour.
- Latency: 3 cycles from input transfer to out_valid when unstalled. Throughput 1 per cycle.
- S1, fold:
  - y >= HALF: neg=0, yf=y.
  - y < HALF: neg=1, yf=ONE-y.
- S2, segment select on yf.
  - Thresholds: T = {936, 1434, 1687, 1783, 1827, 1849, 1858, 1864, 1872}.
  - Intercepts: b = {936, 1185, 1434, 1609, 1719, 1785, 1821, 1843}.
  - Segment k = largest k in 0..7 with T[k] <= yf < T[k+1]. Register k and d = yf - b[k]; d is always >= 0.
  - yf >= 1872 (any y > ONE, y = ONE, or y = 0): sat=1.
- S3, scale and sign:
  - mag = sat ? X_SAT : d << (k+2).
  - x = neg ? ~mag : mag.
  - One's-complement negation is deliberate; it mirrors the forward path's ~x folding of negative inputs.
- Arithmetic:
  - All widths DATA_W.
  - Maximum shift is 9 with d < 32, so no overflow.
- Boundaries:
  - y = HALF gives x = 0.
  - y = HALF-1 gives neg=1, yf=937, x = ~4.
  - y exactly on a threshold T[k] uses segment k.
  - Simultaneous out transfer and in transfer in the same cycle is allowed; there is no slot loss.
- Reset mid-operation: every in-flight sample is discarded; out_valid=0 on the cycle after reset is sampled.
- x and out_valid are stable while out_valid && !out_ready.

Test Plan:
- Latency and zero point: reset, then in_valid=1 with y=936 for one cycle, out_ready=1 -> out_valid high exactly 3 cycles later with x=0; x=0 and out_valid=0 throughout reset.
- Segment edges: y=1433 -> 1988; y=1434 -> 1992; y=1687 -> 4048; y=1800 -> 6112; y=1864 -> 10752; streamed back-to-back -> results in order on consecutive cycles.
- Negative side: y=900 -> x=0xFFFFFF6F (-145); y=935 -> ~4 = 0xFFFFFFFB.
- Saturation: y=1872 -> 13549; y=5000 -> 13549; y=0 -> ~13549 = 0xFFFFCB12 (-13550).
- Backpressure: out_ready=0, stream y=936,1434,1800,900 from cycle 0 -> first three accepted, in_ready=0 from cycle 3, x=0 held stable. Raise out_ready -> outputs 0, 1992, 6112, -145 in order with no loss or duplication.
- Reset mid-flight: 3 samples in pipe, assert reset one cycle -> out_valid=0 next cycle, no stale outputs afterwards. A fresh y=1434 then yields 1992 after 3 cycles.
